read_sequencer: RTL
===================

READ_SEQUENCER -- requirements
Module: read_sequencer

Interface
REQ-001 Parameter COLS, default 16: number of bit-line columns, equal to the sense-amp column count.
REQ-002 Parameter ROWS, default 16: number of word lines.
REQ-003 Parameter PRE_CYC, default 2: precharge duration in clk cycles, minimum 1.
REQ-004 Parameter WL_CYC, default 2: word-line assertion duration in clk cycles, minimum 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  read request present.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_addr  input  $clog2(ROWS)  row to read; sampled on acceptance.
REQ-010 precharge  output  1  bit-line precharge enable.
REQ-011 wl  output  ROWS  one-hot word-line enables.
REQ-012 sa_en  output  1  sense-amp enable.
REQ-013 preout  input  real [0:COLS-1]  sense-amp analog outputs.
REQ-014 rd_data  output  COLS  captured read word.
REQ-015 rd_valid  output  1  rd_data is valid.
REQ-016 rd_ready  input  1  consumer accepts rd_data.

Function
REQ-017 FSM states SHALL be IDLE, PRECH, WLON, SENSE and HOLD.
REQ-018 req_ready SHALL be 1 only in IDLE; acceptance is req_valid & req_ready, which latches req_addr and moves to PRECH.
REQ-019 In PRECH, precharge SHALL be 1 for exactly PRE_CYC cycles, then the FSM moves to WLON.
REQ-020 In WLON, wl[addr] SHALL be 1 and all other wl bits 0 for exactly WL_CYC cycles, then the FSM moves to SENSE.
REQ-021 In SENSE, wl[addr] and sa_en SHALL both be 1 for exactly one cycle, then the FSM moves to HOLD.
REQ-022 On the SENSE-to-HOLD edge, rd_data[i] SHALL capture 1 if preout[i] > VTH (0.8), else 0.
REQ-023 In HOLD, rd_valid SHALL be 1 and rd_data SHALL remain stable until rd_valid & rd_ready; then the FSM returns to IDLE.
REQ-024 rd_ready asserted while rd_valid is 0 SHALL be ignored.
REQ-025 precharge and any wl bit SHALL never be 1 in the same cycle.
REQ-026 Request-to-rd_valid latency SHALL be PRE_CYC+WL_CYC+1 cycles after the acceptance edge.
REQ-027 req_valid in non-IDLE states SHALL NOT be accepted; the requester holds it.
REQ-028 A single shared down-counter SHALL time PRECH and WLON and reload on each state entry.
REQ-029 An out-of-range req_addr (>= ROWS) SHALL be accepted, SHALL assert no wl bit, and SHALL return rd_data = 0.

Reset
REQ-030 When rst is 1, the block SHALL immediately enter IDLE with precharge=0, wl=0, sa_en=0, rd_valid=0, rd_data=0, counter=0 and req_ready=1, including mid-sequence.
REQ-031 The first request after reset deassertion SHALL be accepted on the first rising edge with req_valid=1.

Configuration
REQ-032 Macro SA_XCHECK_EN SHALL add output rd_err (1 bit).
REQ-033 With SA_XCHECK_EN defined, rd_err SHALL be captured with rd_data and set to 1 if any preout[i] lies strictly between 0.3 and 1.2 (indeterminate level); it is cleared with rd_valid.
REQ-034 Without SA_XCHECK_EN, rd_err and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-035 Package sram_pkg SHALL hold VDD=1.5, VSS=0.0, VTH=0.8, the XCHECK window limits, and the FSM state enum.
REQ-036 Sub-module sa_capture SHALL implement the COLS-wide real-to-bit threshold and the optional X-check; the FSM stays in read_sequencer.

Verification
REQ-037 Defaults, req_addr=5, preout all 1.5 -> precharge 2 cycles, wl=16'h0020 for 3 cycles with sa_en in the last, rd_data=16'hFFFF, rd_valid 5 cycles after acceptance.
REQ-038 preout alternating 1.5/0.0 starting at col0, rd_ready held 0 for 4 cycles -> rd_data=16'h5555, stable through HOLD, IDLE one cycle after rd_ready=1.
REQ-039 rst pulsed during WLON -> wl=0, sa_en=0 and req_ready=1 immediately; a new request completes normally.
REQ-040 req_valid held during a sequence -> exactly one acceptance per IDLE visit, back-to-back reads return the correct words.
REQ-041 With SA_XCHECK_EN, preout[3]=0.75 and others 1.5 -> rd_err=1, rd_data=16'hFFF7; all at 0.0 -> rd_err=0.
REQ-042 Assertion across all tests: precharge & |wl is never 1; wl is always one-hot or zero.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared analog levels, sense thresholds and read FSM state encoding for the SRAM read path.
package sram_pkg;

  localparam real VDD     = 1.5;
  localparam real VSS     = 0.0;
  localparam real VTH     = 0.8;
  localparam real XCHK_LO = 0.3;
  localparam real XCHK_HI = 1.2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRECH = 3'd1,
    WLON  = 3'd2,
    SENSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/sa_capture.sv
// Column-wide sense-amp slicer: real level to bit against VTH.
// Optional SA_XCHECK_EN adds an indeterminate-level flag (err_c).
module sa_capture
  import sram_pkg::*;
#(
  parameter int unsigned COLS = 16
) (
  input  real              preout [0:COLS-1],
  output logic [COLS-1:0]  bits_c
`ifdef SA_XCHECK_EN
  ,
  output logic             err_c
`endif
);

  // Strictly-greater threshold; a level sitting exactly on VTH reads as 0.
  always_comb begin
    bits_c = '0;
`ifdef SA_XCHECK_EN
    err_c  = 1'b0;
`endif
    for (int i = 0; i < int'(COLS); i++) begin
      bits_c[i] = (preout[i] > VTH);
`ifdef SA_XCHECK_EN
      err_c = err_c | ((preout[i] > XCHK_LO) && (preout[i] < XCHK_HI));
`endif
    end
  end

endmodule

// File: rtl/read_sequencer.sv
// SRAM read sequencer: precharge, word-line, sense, then hold the captured word.
// Optional SA_XCHECK_EN adds rd_err, flagging indeterminate sense-amp levels.
module read_sequencer
  import sram_pkg::*;
#(
  parameter int unsigned COLS    = 16,
  parameter int unsigned ROWS    = 16,
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned WL_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(ROWS)-1:0]  req_addr,
  output logic                     precharge,
  output logic [ROWS-1:0]          wl,
  output logic                     sa_en,
  input  real                      preout [0:COLS-1],
  output logic [COLS-1:0]          rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready
`ifdef SA_XCHECK_EN
  ,
  output logic                     rd_err
`endif
);

  localparam int unsigned AW      = $clog2(ROWS);
  localparam int unsigned CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [AW-1:0]     addr;
  logic              addr_ok;
  logic              req_ready_nx, precharge_nx, sa_en_nx, rd_valid_nx;
  logic [ROWS-1:0]   wl_nx;
  logic [COLS-1:0]   bits_c;
  logic              accept_c;
`ifdef SA_XCHECK_EN
  logic              err_c;
`endif

  sa_capture #(.COLS(COLS)) u_sa (
    .preout (preout),
    .bits_c (bits_c)
`ifdef SA_XCHECK_EN
    ,
    .err_c  (err_c)
`endif
  );

  assign accept_c = (state == IDLE) && req_valid && req_ready;

  // Next state and next registered outputs; one counter times both PRECH and WLON.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    req_ready_nx = 1'b0;
    precharge_nx = 1'b0;
    sa_en_nx     = 1'b0;
    rd_valid_nx  = 1'b0;
    wl_nx        = '0;

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          state_nx = PRECH;
          cnt_nx   = CW'(PRE_CYC - 1);
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          state_nx = WLON;
          cnt_nx   = CW'(WL_CYC - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      WLON: begin
        if (cnt == '0) state_nx = SENSE;
        else           cnt_nx   = cnt - CW'(1);
      end
      SENSE: state_nx = HOLD;
      HOLD: begin
        if (rd_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    req_ready_nx = (state_nx == IDLE);
    precharge_nx = (state_nx == PRECH);
    sa_en_nx     = (state_nx == SENSE);
    rd_valid_nx  = (state_nx == HOLD);

    // addr is already latched by the time WLON is entered
    if (addr_ok && ((state_nx == WLON) || (state_nx == SENSE))) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        wl_nx[r] = (32'(addr) == r);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      addr_ok   <= 1'b0;
      req_ready <= 1'b1;
      precharge <= 1'b0;
      wl        <= '0;
      sa_en     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
`ifdef SA_XCHECK_EN
      rd_err    <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= req_ready_nx;
      precharge <= precharge_nx;
      wl        <= wl_nx;
      sa_en     <= sa_en_nx;
      rd_valid  <= rd_valid_nx;
      if (accept_c) begin
        addr    <= req_addr;
        addr_ok <= (32'(req_addr) < ROWS);
      end
      // Out-of-range rows never fired a word line, so they read as zero.
      if (state == SENSE) begin
        rd_data <= addr_ok ? bits_c : '0;
`ifdef SA_XCHECK_EN
        rd_err  <= err_c;
`endif
      end
`ifdef SA_XCHECK_EN
      else if ((state == HOLD) && rd_ready) begin
        rd_err <= 1'b0;
      end
`endif
    end
  end

endmodule
